// File: rtl/simon_key_sched.sv
// Simon128/256 key-expansion sequencer: snapshots init_key on launch and streams
// all round keys, one per cycle, into the round-key RAM.
//
// state  | meaning
// IDLE   | waiting for a launchable request; keys_valid reflects the last run
// LOAD   | writing the four snapshot words k0..k3
// EXPAND | writing k4..k[ROUNDS-1]; one trailing cycle closes the run
module simon_key_sched #(
  parameter int WORD_BITS = 64,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 72,
  parameter int ADDR_BITS = 7,
  parameter logic [0:61] Z_SEQ = 62'b11010001111001101011011000100000010111000011001010010011101111
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [KEY_WORDS*WORD_BITS-1:0] init_key,
  input  logic                           key_compute_start,
  input  logic                           cipher_busy,
  output logic                           rk_we,
  output logic [ADDR_BITS-1:0]           rk_addr,
  output logic [WORD_BITS-1:0]           rk_wdata,
  output logic                           busy,
  output logic                           keys_valid,
  output logic                           start_pending
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  localparam logic [ADDR_BITS-1:0] LAST_LOAD = ADDR_BITS'(KEY_WORDS - 1);
  localparam logic [ADDR_BITS-1:0] DONE_IDX  = ADDR_BITS'(ROUNDS);
  localparam logic [ADDR_BITS-1:0] Z_LEN     = ADDR_BITS'(62);

  state_t               state;
  logic [ADDR_BITS-1:0] idx;
  logic [WORD_BITS-1:0] hist [KEY_WORDS];
  logic [1:0]           rst_sync;
  logic                 rst_int_n;
  logic                 launch;
  logic [ADDR_BITS-1:0] z_off;
  logic [ADDR_BITS-1:0] z_idx;
  logic [5:0]           z_sel;
  logic [WORD_BITS-1:0] tmp_a;
  logic [WORD_BITS-1:0] tmp_b;
  logic [WORD_BITS-1:0] k_next;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign launch = (state == IDLE) && (start_pending || key_compute_start) && !cipher_busy;

  always_comb begin
    z_off  = idx - ADDR_BITS'(KEY_WORDS);
    z_idx  = (z_off >= Z_LEN) ? z_off - Z_LEN : z_off;
    z_sel  = z_idx[5:0];
    tmp_a  = {hist[3][2:0], hist[3][WORD_BITS-1:3]} ^ hist[1];
    tmp_b  = tmp_a ^ {tmp_a[0], tmp_a[WORD_BITS-1:1]};
    k_next = ~hist[0] ^ tmp_b ^ WORD_BITS'(Z_SEQ[z_sel]) ^ WORD_BITS'(3);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state         <= IDLE;
      idx           <= '0;
      rk_we         <= 1'b0;
      rk_addr       <= '0;
      rk_wdata      <= '0;
      busy          <= 1'b0;
      keys_valid    <= 1'b0;
      start_pending <= 1'b0;
      for (int w = 0; w < KEY_WORDS; w++) hist[w] <= '0;
    end else begin
      start_pending <= launch ? 1'b0 : (start_pending | key_compute_start);
      rk_we         <= 1'b0;
      rk_addr       <= '0;
      rk_wdata      <= '0;
      case (state)
        IDLE: begin
          if (launch) begin
            for (int w = 0; w < KEY_WORDS; w++)
              hist[w] <= init_key[w*WORD_BITS +: WORD_BITS];
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            idx        <= '0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          rk_we    <= 1'b1;
          rk_addr  <= idx;
          rk_wdata <= hist[idx[1:0]];
          idx      <= idx + 1'b1;
          if (idx == LAST_LOAD) state <= EXPAND;
        end
        EXPAND: begin
          if (idx == DONE_IDX) begin
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            idx        <= '0;
            state      <= IDLE;
          end else begin
            rk_we    <= 1'b1;
            rk_addr  <= idx;
            rk_wdata <= k_next;
            hist[0]  <= hist[1];
            hist[1]  <= hist[2];
            hist[2]  <= hist[3];
            hist[3]  <= k_next;
            idx      <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_sched.sv
// Scoreboard bench for simon_key_sched: a reference key expansion queues the
// expected RAM writes at launch time; a negedge monitor pops and compares them.
module tb_simon_key_sched;

  localparam logic [255:0] K1 = 256'h1f1e1d1c1b1a1918_17161514131211100f0e0d0c0b0a0908_0706050403020100;
  localparam logic [255:0] K2 = 256'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_0123456789abcdef_fedcba9876543210;

  typedef struct {
    logic [6:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic         clk;
  logic         rst_n;
  logic [255:0] init_key;
  logic         key_compute_start;
  logic         cipher_busy;
  logic         rk_we;
  logic [6:0]   rk_addr;
  logic [63:0]  rk_wdata;
  logic         busy;
  logic         keys_valid;
  logic         start_pending;

  wr_t          exp_q[$];
  wr_t          e;
  logic [63:0]  wr_data [0:127];
  int           wr_cnt = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           w0;

  simon_key_sched dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .init_key          (init_key),
    .key_compute_start (key_compute_start),
    .cipher_busy       (cipher_busy),
    .rk_we             (rk_we),
    .rk_addr           (rk_addr),
    .rk_wdata          (rk_wdata),
    .busy              (busy),
    .keys_valid        (keys_valid),
    .start_pending     (start_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, expv);
    end
  endtask

  // Reference Simon128/256 expansion; z is read as a left-to-right bit string.
  task automatic push_run(input logic [255:0] key);
    logic [63:0] k [0:71];
    logic [63:0] t;
    logic [61:0] z;
    z = 62'b11010001111001101011011000100000010111000011001010010011101111;
    for (int i = 0; i < 4; i++) k[i] = key[64*i +: 64];
    for (int i = 4; i < 72; i++) begin
      t = {k[i-1][2:0], k[i-1][63:3]} ^ k[i-3];
      t = t ^ {t[0], t[63:1]};
      k[i] = ~k[i-4] ^ t ^ {63'b0, z[61 - ((i - 4) % 62)]} ^ 64'h3;
    end
    for (int i = 0; i < 72; i++) exp_q.push_back('{addr: 7'(i), data: k[i]});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    key_compute_start = 1'b1;
    tick(1);
    key_compute_start = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (keys_valid !== 1'b1 && n < max_cyc) begin
      tick(1);
      n++;
    end
    chk("done_timeout", keys_valid, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rk_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rk_addr", rk_addr, e.addr);
          chk("rk_wdata", rk_wdata, e.data);
          wr_data[rk_addr] = rk_wdata;
        end
      end else begin
        chk("idle_bus_zero", (rk_addr == 0 && rk_wdata == 0) ? 0 : 1, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_compute_start = 1'b0;
    cipher_busy = 1'b0;
    init_key = K1;
    tick(3);
    chk("rst_rk_we", rk_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_keys_valid", keys_valid, 0);
    chk("rst_pending", start_pending, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(4);

    // 1: basic run and launch-to-valid latency
    push_run(K1);
    pulse_start();
    chk("t1_busy_after_launch", busy, 1);
    chk("t1_kv_after_launch", keys_valid, 0);
    for (int c = 1; c <= 73; c++) begin
      tick(1);
      if (c == 72) chk("t1_kv_cycle72", keys_valid, 0);
      if (c == 73) begin
        chk("t1_kv_cycle73", keys_valid, 1);
        chk("t1_busy_cycle73", busy, 0);
      end
    end
    chk("t1_addr0", wr_data[0], 64'h0706050403020100);
    chk("t1_addr3", wr_data[3], 64'h1f1e1d1c1b1a1918);
    chk("t1_queue_empty", exp_q.size(), 0);

    // 2: request held off by cipher_busy
    w0 = wr_cnt;
    cipher_busy = 1'b1;
    pulse_start();
    tick(5);
    chk("t2_pending", start_pending, 1);
    chk("t2_no_busy", busy, 0);
    chk("t2_kv_kept", keys_valid, 1);
    chk("t2_no_writes", wr_cnt - w0, 0);
    push_run(K1);
    cipher_busy = 1'b0;
    tick(1);
    chk("t2_launch_kv", keys_valid, 0);
    chk("t2_launch_busy", busy, 1);
    chk("t2_launch_pending", start_pending, 0);
    wait_valid(100);
    chk("t2_write_count", wr_cnt - w0, 72);

    // 3: request mid-run chains into a second run
    init_key = K2;
    push_run(K2);
    pulse_start();
    tick(31);
    chk("t3_at_i30", rk_addr, 30);
    push_run(K2);
    pulse_start();
    wait_valid(100);
    chk("t3_pending_between", start_pending, 1);
    chk("t3_kv_between", keys_valid, 1);
    tick(1);
    chk("t3_kv_relaunch", keys_valid, 0);
    chk("t3_busy_relaunch", busy, 1);
    wait_valid(100);
    chk("t3_queue_empty", exp_q.size(), 0);

    // 4: several requests during a run collapse into one
    init_key = K1;
    w0 = wr_cnt;
    push_run(K1);
    pulse_start();
    tick(5);
    pulse_start();
    tick(20);
    pulse_start();
    tick(20);
    pulse_start();
    push_run(K1);
    wait_valid(100);
    tick(1);
    chk("t4_second_launch", busy, 1);
    wait_valid(100);
    tick(10);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_pending", start_pending, 0);
    chk("t4_write_count", wr_cnt - w0, 144);
    chk("t4_queue_empty", exp_q.size(), 0);

    // 5: reset mid-run
    init_key = K2;
    push_run(K2);
    pulse_start();
    tick(51);
    chk("t5_at_i50", rk_addr, 50);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_rk_we", rk_we, 0);
    chk("t5_rst_addr", rk_addr, 0);
    chk("t5_rst_wdata", rk_wdata, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_kv", keys_valid, 0);
    chk("t5_rst_pending", start_pending, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(4);
    chk("t5_post_busy", busy, 0);
    chk("t5_post_kv", keys_valid, 0);
    init_key = K1;
    w0 = wr_cnt;
    push_run(K1);
    pulse_start();
    wait_valid(100);
    chk("t5_write_count", wr_cnt - w0, 72);
    chk("t5_addr0", wr_data[0], 64'h0706050403020100);

    // 6: init_key change mid-run only affects the next launch
    init_key = K2;
    push_run(K2);
    pulse_start();
    tick(11);
    init_key = K1;
    wait_valid(100);
    chk("t6_addr0_snapshot", wr_data[0], K2[63:0]);
    chk("t6_addr3_snapshot", wr_data[3], K2[255:192]);
    push_run(K1);
    pulse_start();
    wait_valid(100);
    chk("t6_addr0_new", wr_data[0], K1[63:0]);

    tick(3);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
